// File: rtl/RSA_pkg.sv
// Shared types for the Montgomery-style halving block: operand width,
// round-count type and the request/result records.
package RSA_pkg;
  localparam int MOD_WIDTH = 256;

  typedef logic [31:0] IntType;

  typedef struct packed {
    logic [MOD_WIDTH-1:0] value;
    IntType               power;
    logic [MOD_WIDTH-1:0] modulus;
  } RSAHalfPowerModIn;

  typedef logic [MOD_WIDTH-1:0] RSAHalfPowerModOut;
endpackage

// File: rtl/rsa_mod_halve.sv
// One modular halving step: multiply acc by 2^-1 mod an odd modulus.
// An odd acc gets the modulus added first so the sum is even.
module rsa_mod_halve #(
  parameter int W = 256
) (
  input  logic [W:0]   acc,
  input  logic [W-1:0] modulus,
  output logic [W:0]   res
);
  logic [W:0] sum;

  // acc < modulus keeps the sum below 2^(W+1), so the carry lives in bit W
  assign sum = acc + {1'b0, modulus};
  assign res = acc[0] ? (sum >> 1) : (acc >> 1);
endmodule

// File: rtl/rsa_half_power_mod.sv
// Computes value * 2^(-power) mod modulus, one halving per clock,
// behind a valid/ready request and result handshake.
module rsa_half_power_mod
  import RSA_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  RSAHalfPowerModIn  i_in,
  output logic              o_valid,
  input  logic              o_ready,
  output RSAHalfPowerModOut o_out
);
  typedef enum logic [1:0] {IDLE, CALCULATE, WAITDONE} state_t;

  state_t               state;
  logic [MOD_WIDTH:0]   acc;
  logic [MOD_WIDTH:0]   acc_next;
  IntType               power;
  IntType               cnt;
  logic [MOD_WIDTH-1:0] modulus;

  rsa_mod_halve #(.W(MOD_WIDTH)) u_halve (
    .acc     (acc),
    .modulus (modulus),
    .res     (acc_next)
  );

  assign i_ready = (state == IDLE);
  assign o_valid = (state == WAITDONE);
  assign o_out   = acc[MOD_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      acc     <= '0;
      power   <= '0;
      cnt     <= '0;
      modulus <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          acc     <= {1'b0, i_in.value};
          power   <= i_in.power;
          modulus <= i_in.modulus;
          cnt     <= '0;
          state   <= (i_in.power == '0) ? WAITDONE : CALCULATE;
        end
        CALCULATE: begin
          acc <= acc_next;
          // exit on the edge doing the last round so latency equals power
          if (cnt == power - IntType'(1)) begin
            cnt   <= '0;
            state <= WAITDONE;
          end else begin
            cnt <= cnt + IntType'(1);
          end
        end
        WAITDONE: if (o_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_half_power_mod.sv
// Randomized and directed checks of rsa_half_power_mod against a
// modular-arithmetic reference (forward doubling, then inverse via the DUT).
module tb_rsa_half_power_mod;
  import RSA_pkg::*;

  localparam int W = MOD_WIDTH;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_valid = 1'b0;
  logic              i_ready;
  RSAHalfPowerModIn  i_in = '0;
  logic              o_valid;
  logic              o_ready = 1'b0;
  RSAHalfPowerModOut o_out;

  int n_tests = 0;
  int n_fail  = 0;

  rsa_half_power_mod dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_in    (i_in),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_out   (o_out)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // x * 2^k mod m by repeated modular doubling
  function automatic logic [W-1:0] mul_pow2_mod(logic [W-1:0] x, int k, logic [W-1:0] m);
    logic [2*W-1:0] p, mm, xx;
    mm = {{W{1'b0}}, m};
    xx = {{W{1'b0}}, x};
    p  = 1 % mm;
    for (int i = 0; i < k; i++) p = (p << 1) % mm;
    p = (xx * p) % mm;
    return p[W-1:0];
  endfunction

  // Drive a request from a negedge, hold until accepted; returns ok=0 on timeout
  task automatic send_req(input logic [W-1:0] v, input IntType p, input logic [W-1:0] m, output bit ok);
    int n;
    i_in.value = v; i_in.power = p; i_in.modulus = m;
    i_valid = 1'b1;
    n = 0;
    while (!i_ready && n < 200) begin @(posedge clk); @(negedge clk); n++; end
    ok = i_ready;
    if (ok) begin @(posedge clk); @(negedge clk); end
    i_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until o_valid is seen (at negedge)
  task automatic wait_valid(input int limit, output int lat, output bit ok);
    lat = 0;
    while (!o_valid && lat < limit) begin @(posedge clk); @(negedge clk); lat++; end
    ok = o_valid;
  endtask

  task automatic consume();
    o_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    o_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0 || o_out !== '0) begin
      n_fail++;
      $display("FAIL reset: i_ready=%b o_valid=%b o_out=%0h, want 1 0 0", i_ready, o_valid, o_out);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_one(input string name, input logic [W-1:0] v, input IntType p,
                         input logic [W-1:0] m, input logic [W-1:0] exp);
    bit ok; int lat;
    send_req(v, p, m, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s accept: i_ready never high", name); return; end
    wait_valid(int'(p) + 10, lat, ok);
    n_tests++;
    if (!ok || lat != int'(p)) begin
      n_fail++;
      $display("FAIL %s latency: got %0d (valid=%b), want %0d", name, lat, ok, p);
    end
    n_tests++;
    if (o_out !== exp) begin
      n_fail++;
      $display("FAIL %s value: got %0h, want %0h", name, o_out, exp);
    end
    if (ok) consume();
  endtask

  task automatic test_vectors();
    logic [W-1:0] m13;
    m13 = W'(13);
    run_one("v5p3", W'(5), 32'd3, m13, W'(12));
    run_one("v6p2", W'(6), 32'd2, m13, W'(8));
    run_one("v9p0", W'(9), 32'd0, m13, W'(9));
  endtask

  task automatic test_carry();
    logic [W-1:0] m;
    m = '1;
    run_one("carry", m - W'(1), IntType'(W), m, m - W'(1));
  endtask

  task automatic test_backpressure();
    bit ok; int lat;
    send_req(W'(1), 32'd1, W'(13), ok);
    wait_valid(20, lat, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL bp valid: o_valid never high"); return; end
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1;
      i_in.value = rand_wide(); i_in.power = 32'd0; i_in.modulus = W'(13);
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (o_valid !== 1'b1 || i_ready !== 1'b0 || o_out !== W'(7)) begin
        n_fail++;
        $display("FAIL bp hold %0d: o_valid=%b i_ready=%b o_out=%0h, want 1 0 7", i, o_valid, i_ready, o_out);
      end
    end
    i_valid = 1'b0;
    consume();
    n_tests++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp release: i_ready=%b o_valid=%b, want 1 0", i_ready, o_valid);
    end
  endtask

  task automatic test_reset_abort();
    bit ok; int seen;
    send_req(W'(5), 32'd100, W'(13), ok);
    repeat (10) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
    #1;
    n_tests++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0 || o_out !== '0) begin
      n_fail++;
      $display("FAIL abort in reset: i_ready=%b o_valid=%b o_out=%0h, want 1 0 0", i_ready, o_valid, o_out);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); @(negedge clk);
      if (o_valid) seen++;
    end
    n_tests++;
    if (seen != 0 || i_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort quiet: o_valid cycles=%0d i_ready=%b, want 0 1", seen, i_ready);
    end
    run_one("after_abort", W'(5), 32'd3, W'(13), W'(12));
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] m, x, y;
    int k, lat, bad;
    bit ok;
    bad = 0;
    for (int it = 0; it < 1000; it++) begin
      m = rand_wide() | W'(1);
      if (m < W'(3)) m = W'(13);
      x = rand_wide() % m;
      k = $urandom_range(0, 60);
      y = mul_pow2_mod(x, k, m);
      send_req(y, IntType'(k), m, ok);
      if (ok) wait_valid(k + 10, lat, ok);
      n_tests++;
      if (!ok || lat != k || o_out !== x) begin
        n_fail++;
        if (bad < 5)
          $display("FAIL roundtrip %0d: k=%0d lat=%0d got %0h, want %0h", it, k, lat, o_out, x);
        bad++;
      end
      if (ok) begin
        o_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        o_ready = 1'b0;
      end else begin
        // recover to a clean IDLE before the next iteration
        rst = 1'b0; @(negedge clk); rst = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_carry();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rsa_half_power_mod.md
RSA_HALF_POWER_MOD -- requirements
Module: rsa_half_power_mod

Interface
REQ-001 SHALL take parameters from RSA_pkg: MOD_WIDTH (default 256), operand/result width; IntType (32-bit unsigned), round-count type.
REQ-002 SHALL have ports clk, input, 1, clock; all state on rising edge.
REQ-003 SHALL have ports rst, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have ports i_valid, input, 1, request valid.
REQ-005 SHALL have ports i_ready, output, 1, block can accept a request.
REQ-006 SHALL have ports i_in, input, RSAHalfPowerModIn, request fields {value[MOD_WIDTH], power IntType, modulus[MOD_WIDTH]}.
REQ-007 SHALL have ports o_valid, output, 1, result valid.
REQ-008 SHALL have ports o_ready, input, 1, consumer accepts result.
REQ-009 SHALL have ports o_out, output, RSAHalfPowerModOut (MOD_WIDTH bits), value * 2^(-power) mod modulus.

Function
REQ-010 SHALL use three states: IDLE, CALCULATE, WAITDONE; every state's next-state SHALL default to the current state (no latches).
REQ-011 SHALL assert i_ready iff state==IDLE; o_valid iff state==WAITDONE.
REQ-012 SHALL accept a request on a rising edge with i_valid && i_ready, capturing power and modulus and loading accumulator acc (MOD_WIDTH+1 bits) with {0,value}.
REQ-013 On accept, SHALL go to WAITDONE if power==0, else to CALCULATE with round counter 0.
REQ-014 In CALCULATE, each cycle SHALL set acc = (acc + modulus) >> 1 if acc[0]==1, else acc >> 1, and increment the counter; the add SHALL use MOD_WIDTH+1 bits (carry kept).
REQ-015 SHALL leave CALCULATE for WAITDONE on the edge performing round power-1, so WAITDONE is entered exactly power edges after the accepting edge (power==0: on the accepting edge).
REQ-016 SHALL drive o_out = acc[MOD_WIDTH-1:0]; o_out SHALL be stable while o_valid && !o_ready.
REQ-017 SHALL return to IDLE on the edge with o_valid && o_ready; next request accepted no earlier than the following edge.
REQ-018 i_valid in CALCULATE/WAITDONE SHALL be ignored; i_in changes after accept SHALL not affect the result.
REQ-019 Precondition: modulus odd, value < modulus; then result < modulus with no final subtraction; otherwise o_out unspecified but handshake timing per REQ-015/017 unchanged.
REQ-020 Counter SHALL reset to 0 outside CALCULATE; power up to 2^32-1 SHALL be supported without wrap error.

Reset
REQ-021 While rst low: state=IDLE, acc=0, counter=0, captured power/modulus=0; hence i_ready=1, o_valid=0, o_out=0.
REQ-022 Reset asserted mid-CALCULATE or mid-WAITDONE SHALL abort the operation; no o_valid pulse SHALL follow release.

Structure
REQ-023 RSAHalfPowerModIn, RSAHalfPowerModOut, MOD_WIDTH, IntType SHALL live in RSA_pkg; the state enum SHALL be local.
REQ-024 SHALL be a single module; the conditional add-and-halve step MAY be a sub-module rsa_mod_halve (pure combinational, MOD_WIDTH+1 bits).

Verification
REQ-025 modulus=13, value=5, power=3 -> o_out=12, o_valid first high 3 cycles after accept.
REQ-026 modulus=13, value=6, power=2 -> o_out=8; value=9, power=0 -> o_out=9, o_valid the cycle after accept.
REQ-027 modulus=2^MOD_WIDTH-1, value=modulus-1, power=MOD_WIDTH -> o_out=modulus-1 (exercises carry bit).
REQ-028 modulus=13, value=1, power=1 with o_ready low 5 cycles -> o_out=7 held stable, i_ready=0 throughout, i_valid pulses ignored.
REQ-029 rst low 1 cycle mid-CALCULATE (power=100) -> o_valid never asserts; i_ready=1 after release; next request modulus=13, value=5, power=3 -> 12.
REQ-030 Round-trip: random odd modulus, x, k; x*2^k mod modulus then this block with power=k -> x, 1000 iterations, back-to-back requests.
